// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one i2c_master between two clients
module i2c_arbiter #(
  parameter int PKT_W    = 5,
  parameter int MAX_HOLD = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_req,
  output logic             c0_gnt,
  input  logic             c0_start,
  input  logic [6:0]       c0_addr,
  input  logic             c0_rw,
  input  logic [PKT_W-1:0] c0_packets,
  input  logic [7:0]       c0_data,
  output logic             c0_ready,
  output logic             c0_data_req,
  output logic             c0_data_ready,
  input  logic             c1_req,
  output logic             c1_gnt,
  input  logic             c1_start,
  input  logic [6:0]       c1_addr,
  input  logic             c1_rw,
  input  logic [PKT_W-1:0] c1_packets,
  input  logic [7:0]       c1_data,
  output logic             c1_ready,
  output logic             c1_data_req,
  output logic             c1_data_ready,
  output logic [7:0]       data_out,
  output logic             m_start,
  output logic [6:0]       m_addr,
  output logic             m_rw,
  output logic [PKT_W-1:0] m_packets,
  output logic [7:0]       m_data,
  input  logic             m_ready,
  input  logic             m_data_req,
  input  logic             m_data_ready,
  input  logic [7:0]       m_data_out,
  output logic             owner,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] OWNED   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]  state;
  logic        owner_q;
  logic [15:0] hold;
  logic        own_req;
  logic        other_req;
  logic        hold_max;

  assign busy      = (state == OWNED);
  assign c0_gnt    = busy & ~owner_q;
  assign c1_gnt    = busy & owner_q;
  assign owner     = owner_q;
  assign own_req   = owner_q ? c1_req : c0_req;
  assign other_req = owner_q ? c0_req : c1_req;
  assign hold_max  = (hold == 16'(MAX_HOLD));

  assign c0_ready      = m_ready & c0_gnt;
  assign c1_ready      = m_ready & c1_gnt;
  assign c0_data_req   = m_data_req & c0_gnt;
  assign c1_data_req   = m_data_req & c1_gnt;
  assign c0_data_ready = m_data_ready & c0_gnt;
  assign c1_data_ready = m_data_ready & c1_gnt;
  assign data_out      = m_data_out;

  // Start is masked by the owner's req so a client that has given up
  // mid-transaction cannot launch another one before the grant lapses.
  always_comb begin
    m_start   = 1'b0;
    m_addr    = '0;
    m_rw      = 1'b1;
    m_packets = '0;
    m_data    = '0;
    if (c0_gnt) begin
      m_start   = c0_start & c0_req;
      m_addr    = c0_addr;
      m_rw      = c0_rw;
      m_packets = c0_packets;
      m_data    = c0_data;
    end else if (c1_gnt) begin
      m_start   = c1_start & c1_req;
      m_addr    = c1_addr;
      m_rw      = c1_rw;
      m_packets = c1_packets;
      m_data    = c1_data;
    end
  end

  // owner_q doubles as last-owner: it only changes on a grant, so in IDLE it
  // always names the client that held the bus most recently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= 1'b1;
      hold    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_ready && (c0_req || c1_req)) begin
            state   <= OWNED;
            owner_q <= (c0_req && c1_req) ? ~owner_q : c1_req;
          end
        end
        OWNED: begin
          if (!m_ready)
            hold <= '0;
          else if (other_req && !hold_max)
            hold <= hold + 16'd1;
          if (m_ready && !m_start && (!own_req || hold_max))
            state <= RELEASE;
        end
        RELEASE: begin
          hold  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
